conv1d_stream_par: RTL and testbench

Parametrised 1-D convolution engine, the successor to the fixed-size ROM-filter conv blocks. It differs from them in three ways: both the input vector X and the filter F arrive over valid/ready streams, P parallel MAC lanes compute P outputs per pass, and ReLU is selectable. Each job works as follows: load N X-words and M F-words, produce N-M+1 saturated outputs on a valid/ready output stream, then return to loading. The block sits between the layer's input stream and the next layer or output stream.

---
 rtl/conv1d_stream_par.sv | 192 +++++++++++++++++++
 tb/tb_conv1d_stream_par.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_stream_par.sv
// rtl/conv1d_stream_par.sv - streaming 1-D convolution with P parallel saturating MAC lanes
// Each job loads N x-words and M f-words, then emits N-M+1 outputs, P lanes per compute pass.
module conv1d_stream_par #(
  parameter int T    = 16,
  parameter int N    = 64,
  parameter int M    = 33,
  parameter int P    = 1,
  parameter int RELU = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] s_data_in_x,
  input  logic         s_valid_x,
  output logic         s_ready_x,
  input  logic [T-1:0] s_data_in_f,
  input  logic         s_valid_f,
  output logic         s_ready_f,
  output logic [T-1:0] m_data_out_y,
  output logic         m_valid_y,
  input  logic         m_ready_y
);

  localparam int NOUT = N - M + 1;
  localparam int XW   = $clog2(N + 1);
  localparam int FW   = $clog2(M + 1);
  localparam int LW   = (P > 1) ? $clog2(P) : 1;
  localparam logic signed [T-1:0] SMAX = {1'b0, {(T-1){1'b1}}};
  localparam logic signed [T-1:0] SMIN = {1'b1, {(T-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [FW-1:0] f_cnt_q, f_cnt_d;
  logic [FW-1:0] k_q, k_d;
  logic [XW-1:0] base_q, base_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          rdy_x_q, rdy_x_d, rdy_f_q, rdy_f_d;
  logic          v1_q, last1_q, v2_q, last2_q;
  logic          rd_en, acc_clr;
  logic          x_fire, f_fire, y_fire;

  logic signed [T-1:0] x_mem [2**XW];
  logic signed [T-1:0] f_mem [2**FW];
  logic signed [T-1:0] xr_q [P];
  logic signed [T-1:0] fr_q;
  logic signed [T-1:0] prod_q [P];
  logic signed [T-1:0] acc_q [P];
  logic signed [T-1:0] y_sel;

  // Sign-extended operands make the low 2T bits of the unsigned product the exact signed product.
  function automatic logic signed [T-1:0] sat_mul(input logic signed [T-1:0] a,
                                                  input logic signed [T-1:0] b);
    logic [2*T-1:0] p;
    p = {{T{a[T-1]}}, a} * {{T{b[T-1]}}, b};
    if (p[2*T-1:T-1] != '0 && p[2*T-1:T-1] != '1) return p[2*T-1] ? SMIN : SMAX;
    return p[T-1:0];
  endfunction

  function automatic logic signed [T-1:0] sat_add(input logic signed [T-1:0] a,
                                                  input logic signed [T-1:0] b);
    logic [T:0] s;
    s = {a[T-1], a} + {b[T-1], b};
    if (s[T] != s[T-1]) return s[T] ? SMIN : SMAX;
    return s[T-1:0];
  endfunction

  assign x_fire    = s_valid_x & rdy_x_q;
  assign f_fire    = s_valid_f & rdy_f_q;
  assign m_valid_y = (state_q == OUTPUT);
  assign y_fire    = m_valid_y & m_ready_y;
  assign s_ready_x = rdy_x_q;
  assign s_ready_f = rdy_f_q;

  always_comb begin
    state_d = state_q;
    x_cnt_d = x_cnt_q;
    f_cnt_d = f_cnt_q;
    k_d     = k_q;
    base_d  = base_q;
    lane_d  = lane_q;
    rd_en   = 1'b0;
    acc_clr = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (x_fire) x_cnt_d = x_cnt_q + 1'b1;
        if (f_fire) f_cnt_d = f_cnt_q + 1'b1;
        if (x_cnt_d == XW'(N) && f_cnt_d == FW'(M)) begin
          state_d = COMPUTE;
          k_d     = '0;
          base_d  = '0;
          acc_clr = 1'b1;
        end
      end
      COMPUTE: begin
        rd_en = (k_q != FW'(M));
        if (rd_en) k_d = k_q + 1'b1;
        if (last2_q) begin
          state_d = OUTPUT;
          lane_d  = '0;
        end
      end
      OUTPUT: begin
        if (y_fire) begin
          if (lane_q == LW'(P - 1)) begin
            lane_d = '0;
            if (base_q == XW'(NOUT - P)) begin
              state_d = LOAD;
              x_cnt_d = '0;
              f_cnt_d = '0;
            end else begin
              state_d = COMPUTE;
              base_d  = base_q + XW'(P);
              k_d     = '0;
              acc_clr = 1'b1;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    rdy_x_d = (state_d == LOAD) && (x_cnt_d != XW'(N));
    rdy_f_d = (state_d == LOAD) && (f_cnt_d != FW'(M));
  end

  always_ff @(posedge clk) begin
    if (x_fire) x_mem[x_cnt_q] <= s_data_in_x;
    if (f_fire) f_mem[f_cnt_q] <= s_data_in_f;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      x_cnt_q <= '0;
      f_cnt_q <= '0;
      k_q     <= '0;
      base_q  <= '0;
      lane_q  <= '0;
      rdy_x_q <= 1'b0;
      rdy_f_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_cnt_q <= x_cnt_d;
      f_cnt_q <= f_cnt_d;
      k_q     <= k_d;
      base_q  <= base_d;
      lane_q  <= lane_d;
      rdy_x_q <= rdy_x_d;
      rdy_f_q <= rdy_f_d;
    end
  end

  // Read stage -> product stage -> accumulate; the last flag rides alongside to end the pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      fr_q    <= '0;
      for (int p = 0; p < P; p++) begin
        xr_q[p]   <= '0;
        prod_q[p] <= '0;
        acc_q[p]  <= '0;
      end
    end else begin
      v1_q    <= rd_en;
      last1_q <= rd_en && (k_q == FW'(M - 1));
      v2_q    <= v1_q;
      last2_q <= last1_q;
      if (rd_en) fr_q <= f_mem[k_q];
      for (int p = 0; p < P; p++) begin
        if (rd_en) xr_q[p] <= x_mem[base_q + XW'(p) + XW'(k_q)];
        if (v1_q) prod_q[p] <= sat_mul(xr_q[p], fr_q);
        if (acc_clr) acc_q[p] <= '0;
        else if (v2_q) acc_q[p] <= sat_add(acc_q[p], prod_q[p]);
      end
    end
  end

  always_comb begin
    y_sel = '0;
    for (int p = 0; p < P; p++) begin
      if (lane_q == LW'(p)) y_sel = acc_q[p];
    end
  end

  assign m_data_out_y = (!m_valid_y || (RELU != 0 && y_sel[T-1])) ? '0 : y_sel;

endmodule

// File: tb/tb_conv1d_stream_par.sv
// tb/tb_conv1d_stream_par.sv - scoreboard bench for conv1d_stream_par, ReLU and linear instances
module tb_conv1d_stream_par;
  localparam int T    = 16;
  localparam int N    = 9;
  localparam int M    = 4;
  localparam int P    = 2;
  localparam int NOUT = N - M + 1;
  localparam longint SMAX = (longint'(1) << (T - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (T - 1));

  logic         clk = 1'b0;
  logic         reset;
  logic [T-1:0] x_data, f_data;
  logic         x_valid, f_valid, y_ready;
  logic         rx_a, rf_a, vy_a, rx_b, rf_b, vy_b;
  logic [T-1:0] y_a, y_b;

  always #5 clk = ~clk;

  conv1d_stream_par #(.T(T), .N(N), .M(M), .P(P), .RELU(1)) u_relu (
    .clk(clk), .reset(reset),
    .s_data_in_x(x_data), .s_valid_x(x_valid), .s_ready_x(rx_a),
    .s_data_in_f(f_data), .s_valid_f(f_valid), .s_ready_f(rf_a),
    .m_data_out_y(y_a), .m_valid_y(vy_a), .m_ready_y(y_ready)
  );

  conv1d_stream_par #(.T(T), .N(N), .M(M), .P(P), .RELU(0)) u_lin (
    .clk(clk), .reset(reset),
    .s_data_in_x(x_data), .s_valid_x(x_valid), .s_ready_x(rx_b),
    .s_data_in_f(f_data), .s_valid_f(f_valid), .s_ready_f(rf_b),
    .m_data_out_y(y_b), .m_valid_y(vy_b), .m_ready_y(y_ready)
  );

  int           vecs = 0;
  int           errs = 0;
  logic [T-1:0] exp_a[$];
  logic [T-1:0] exp_b[$];
  int           cur_x [N];
  int           cur_f [M];
  bit           x_done = 1'b0;
  bit           f_done = 1'b0;
  int           rdy_mode = 1;
  int           allow = 0;

  task automatic check(input string name, input int got, input int want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic longint clamp(input longint v);
    return (v > SMAX) ? SMAX : ((v < SMIN) ? SMIN : v);
  endfunction

  // Reference: direct dot product per output index with per-step saturation.
  task automatic push_expected();
    longint acc;
    for (int i = 0; i < NOUT; i++) begin
      acc = 0;
      for (int k = 0; k < M; k++)
        acc = clamp(acc + clamp(longint'(cur_x[i + k]) * longint'(cur_f[k])));
      exp_b.push_back(T'(acc));
      exp_a.push_back((acc < 0) ? T'(0) : T'(acc));
    end
  endtask

  task automatic drive_x(input bit rnd);
    int i = 0;
    int guard = 0;
    while (i < N) begin
      @(negedge clk);
      guard++;
      if (guard > 4000) begin
        check("x_load_timeout", i, N);
        break;
      end
      x_data  = T'(cur_x[i]);
      x_valid = rnd ? 1'($urandom_range(1)) : 1'b1;
      if (x_valid && rx_b) i++;
    end
    @(negedge clk);
    x_valid = 1'b0;
    x_done  = 1'b1;
  endtask

  task automatic drive_f(input bit rnd);
    int i = 0;
    int guard = 0;
    while (i < M) begin
      @(negedge clk);
      guard++;
      if (guard > 4000) begin
        check("f_load_timeout", i, M);
        break;
      end
      f_data  = T'(cur_f[i]);
      f_valid = rnd ? 1'($urandom_range(1)) : 1'b1;
      if (f_valid && rf_b) i++;
    end
    @(negedge clk);
    f_valid = 1'b0;
    f_done  = 1'b1;
  endtask

  task automatic flush();
    exp_a.delete();
    exp_b.delete();
    x_done = 1'b0;
    f_done = 1'b0;
  endtask

  task automatic check_ready(input string tag);
    check({tag, "_rdy_x_lin"}, int'(rx_b), 1);
    check({tag, "_rdy_f_lin"}, int'(rf_b), 1);
    check({tag, "_rdy_x_relu"}, int'(rx_a), 1);
    check({tag, "_rdy_f_relu"}, int'(rf_a), 1);
  endtask

  task automatic run_job(input bit rnd);
    int guard = 0;
    push_expected();
    rdy_mode = rnd ? 0 : 1;
    fork
      drive_x(rnd);
      drive_f(rnd);
    join
    while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("job_outputs_left", exp_a.size() + exp_b.size(), 0);
    flush();
    @(posedge clk);
    #1;
    check_ready("after_job");
  endtask

  task automatic load_test1();
    for (int i = 0; i < N; i++) cur_x[i] = i + 1;
    for (int k = 0; k < M; k++) cur_f[k] = 1;
  endtask

  task automatic reset_mid(input bit in_output);
    int guard = 0;
    load_test1();
    push_expected();
    rdy_mode = 2;
    allow    = in_output ? 1 : 0;
    fork
      drive_x(1'b0);
      drive_f(1'b0);
    join
    if (in_output) begin
      while (exp_b.size() > NOUT - 1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
      @(negedge clk);
      check("stalled_valid_before_reset", int'(vy_b), 1);
    end else begin
      @(negedge clk);
      check("computing_valid_before_reset", int'(vy_b), 0);
    end
    #2 reset = 1'b0;
    #1;
    check("abort_valid_lin", int'(vy_b), 0);
    check("abort_valid_relu", int'(vy_a), 0);
    check("abort_data_lin", int'(y_b), 0);
    check("abort_rdy_x", int'(rx_b), 0);
    flush();
    allow    = 0;
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check_ready("after_abort");
  endtask

  function automatic int rand_word(input int mode);
    logic [T-1:0] r;
    r = T'($urandom);
    return (mode % 2 == 0) ? int'($signed(r)) : int'($urandom_range(0, 200)) - 100;
  endfunction

  // Monitor: pops the scoreboard on every output handshake and polices stalls and load exclusion.
  initial begin
    bit           stall_a = 1'b0;
    bit           stall_b = 1'b0;
    logic [T-1:0] hold_a = '0;
    logic [T-1:0] hold_b = '0;
    logic [T-1:0] e;
    y_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_a = 1'b0;
        stall_b = 1'b0;
        y_ready = 1'b0;
      end else begin
        if (stall_b) check("y_lin_stall_hold", int'({vy_b, y_b}), int'({1'b1, hold_b}));
        if (stall_a) check("y_relu_stall_hold", int'({vy_a, y_a}), int'({1'b1, hold_a}));
        if (!vy_b) check("y_lin_idle_zero", int'(y_b), 0);
        if (!vy_a) check("y_relu_idle_zero", int'(y_a), 0);
        if (x_done && exp_b.size() != 0) check("rdy_x_outside_load", int'(rx_b | rx_a), 0);
        if (f_done && exp_b.size() != 0) check("rdy_f_outside_load", int'(rf_b | rf_a), 0);
        case (rdy_mode)
          0:       y_ready = 1'($urandom_range(1));
          1:       y_ready = 1'b1;
          default: y_ready = (allow > 0);
        endcase
        if (vy_b && y_ready) begin
          if (exp_b.size() == 0) check("y_lin_unexpected_output", 1, 0);
          else begin
            e = exp_b.pop_front();
            check("y_lin", int'($signed(y_b)), int'($signed(e)));
          end
          if (allow > 0) allow--;
        end
        if (vy_a && y_ready) begin
          if (exp_a.size() == 0) check("y_relu_unexpected_output", 1, 0);
          else begin
            e = exp_a.pop_front();
            check("y_relu", int'($signed(y_a)), int'($signed(e)));
          end
        end
        stall_b = vy_b && !y_ready;
        stall_a = vy_a && !y_ready;
        hold_b  = y_b;
        hold_a  = y_a;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    x_valid = 1'b0;
    f_valid = 1'b0;
    x_data  = '0;
    f_data  = '0;
    #2 reset = 1'b0;
    #1;
    check("reset_rdy_x", int'(rx_b), 0);
    check("reset_rdy_f", int'(rf_b), 0);
    check("reset_valid_lin", int'(vy_b), 0);
    check("reset_valid_relu", int'(vy_a), 0);
    check("reset_data_lin", int'(y_b), 0);
    check("reset_data_relu", int'(y_a), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check_ready("after_reset");

    load_test1();
    run_job(1'b0);

    for (int k = 0; k < M; k++) cur_f[k] = -1;
    run_job(1'b0);

    for (int i = 0; i < N; i++) cur_x[i] = 32767;
    for (int k = 0; k < M; k++) cur_f[k] = 32767;
    run_job(1'b0);
    for (int i = 0; i < N; i++) cur_x[i] = -32768;
    run_job(1'b0);

    load_test1();
    run_job(1'b1);

    reset_mid(1'b0);
    reset_mid(1'b1);
    load_test1();
    run_job(1'b0);

    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < N; i++) cur_x[i] = rand_word(j + i);
      for (int k = 0; k < M; k++) cur_f[k] = rand_word(j + k + 1);
      run_job(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
